uart_note_receiver: RTL and testbench

//  Serial note front-end for the keyboard path. Receives 8N1 UART bytes from the

---
 rtl/uart_note_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_note_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_note_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_note_receiver
// Description : 8N1 UART receiver that decodes keyboard note-on/off bytes
//               into a held 7-bit note code, with an inactivity timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_note_receiver #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       rx_in,
  output logic [6:0] note_out,
  output logic       note_valid,
  output logic       frame_err
);

  localparam int BIT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [BIT_W-1:0]  HALF_BIT_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  FULL_BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST     = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t             state;
  logic               rx_meta;
  logic               rx_sync;
  logic [BIT_W-1:0]   bit_timer;
  logic [2:0]         bit_idx;
  logic [7:0]         data_sr;
  logic               byte_valid;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               stop_fail;

  // Synchronizer resets low so a line stuck low out of reset is never taken as idle.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state      <= WAIT_IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      data_sr    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (rx_sync) state <= IDLE;
        end
        IDLE: begin
          if (!rx_sync) begin
            state     <= START;
            bit_timer <= '0;
          end
        end
        START: begin
          if (bit_timer == HALF_BIT_LAST) begin
            bit_timer <= '0;
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            bit_timer <= bit_timer + BIT_W'(1);
          end
        end
        DATA: begin
          if (bit_timer == FULL_BIT_LAST) begin
            bit_timer <= '0;
            data_sr   <= {rx_sync, data_sr[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_timer <= bit_timer + BIT_W'(1);
          end
        end
        STOP: begin
          if (bit_timer == FULL_BIT_LAST) begin
            bit_timer <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            bit_timer <= bit_timer + BIT_W'(1);
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // A timeout landing on a frame-error cycle is held off one cycle by the saturated counter.
  assign stop_fail = (state == STOP) && (bit_timer == FULL_BIT_LAST) && !rx_sync;

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      note_out   <= '0;
      note_valid <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      note_valid <= 1'b0;
      if (byte_valid) begin
        idle_cnt <= '0;
        if (data_sr[7]) begin
          if (data_sr[6:0] != note_out) begin
            note_out   <= data_sr[6:0];
            note_valid <= 1'b1;
          end
        end else if ((data_sr[6:0] == note_out || data_sr[6:0] == 7'd0) && note_out != 7'd0) begin
          note_out   <= '0;
          note_valid <= 1'b1;
        end
      end else if (idle_cnt == IDLE_LAST) begin
        if (note_out != 7'd0 && !stop_fail) begin
          note_out   <= '0;
          note_valid <= 1'b1;
        end
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_note_receiver.sv
`default_nettype none
// Testbench for uart_note_receiver: directed vector table, hand-written corner
// sequences and randomized frames checked against a byte-level note model.
module tb_uart_note_receiver;

  localparam int CPB = 16;
  localparam int TO  = 2000;
  // First sampled edge of the start bit -> stop sample: 2 sync + 8 half-bit + 9*16 bits.
  localparam int STOP_LAT = 2 + CPB / 2 + 9 * CPB;
  localparam int ACC_LAT  = STOP_LAT + 1;

  logic       clk_100mhz = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [6:0] note_out;
  logic       note_valid;
  logic       frame_err;

  uart_note_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .rx_in      (rx_in),
    .note_out   (note_out),
    .note_valid (note_valid),
    .frame_err  (frame_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int cnt_valid = 0, cnt_ferr = 0, last_valid_cyc = -1, last_ferr_cyc = -1;
  int both_cnt = 0, silent_change = 0, empty_pulse = 0;
  logic [6:0] prev_note = '0;

  always @(posedge clk_100mhz) begin
    #1;
    if (!reset) begin
      if (note_valid) begin cnt_valid++; last_valid_cyc = cyc; end
      if (frame_err)  begin cnt_ferr++;  last_ferr_cyc  = cyc; end
      if (note_valid && frame_err) both_cnt++;
      if (note_out != prev_note && !note_valid) silent_change++;
      if (note_valid && note_out == prev_note) empty_pulse++;
    end
    prev_note = note_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int start);
    @(negedge clk_100mhz);
    rx_in = 1'b0;
    start = cyc + 1;
    repeat (CPB) @(negedge clk_100mhz);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk_100mhz);
    end
    rx_in = stop_ok;
    repeat (CPB) @(negedge clk_100mhz);
    rx_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    logic [6:0] note;
    bit         valid;
    bit         ferr;
  } vec_t;

  vec_t vec[13];

  // Reference model state
  logic [6:0] m_note;
  longint     m_deadline;
  int         e_valid, e_ferr;

  function automatic logic [6:0] decode(input logic [6:0] held, input logic [7:0] b);
    if (b[7]) return b[6:0];
    if (b[6:0] == held || b[6:0] == 7'd0) return 7'd0;
    return held;
  endfunction

  initial begin
    int st, v0, f0, n, acc, gap, vb, fb;
    logic [7:0] rb;
    bit ok;
    logic [6:0] nn;

    vec[0]  = '{8'hBC, 1'b1, 7'h3C, 1'b1, 1'b0};
    vec[1]  = '{8'h3C, 1'b1, 7'h00, 1'b1, 1'b0};
    vec[2]  = '{8'h3D, 1'b1, 7'h00, 1'b0, 1'b0};
    vec[3]  = '{8'hBC, 1'b1, 7'h3C, 1'b1, 1'b0};
    vec[4]  = '{8'hBC, 1'b1, 7'h3C, 1'b0, 1'b0};
    vec[5]  = '{8'hC5, 1'b0, 7'h3C, 1'b0, 1'b1};
    vec[6]  = '{8'h80, 1'b1, 7'h00, 1'b1, 1'b0};
    vec[7]  = '{8'h81, 1'b1, 7'h01, 1'b1, 1'b0};
    vec[8]  = '{8'h05, 1'b1, 7'h01, 1'b0, 1'b0};
    vec[9]  = '{8'h01, 1'b1, 7'h00, 1'b1, 1'b0};
    vec[10] = '{8'h80, 1'b1, 7'h00, 1'b0, 1'b0};
    vec[11] = '{8'hFF, 1'b1, 7'h7F, 1'b1, 1'b0};
    vec[12] = '{8'h7F, 1'b1, 7'h00, 1'b1, 1'b0};

    reset = 1'b1;
    rx_in = 1'b1;
    idle(5);
    check("reset_note_out", 32'(note_out), 0);
    check("reset_note_valid", 32'(note_valid), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    reset = 1'b0;
    idle(20);

    for (int i = 0; i < 13; i++) begin
      v0 = cnt_valid;
      f0 = cnt_ferr;
      send_frame(vec[i].b, vec[i].stop_ok, st);
      idle(4);
      check($sformatf("vec%0d_note", i), 32'(note_out), 32'(vec[i].note));
      check($sformatf("vec%0d_pulses", i), cnt_valid - v0, 32'(vec[i].valid));
      check($sformatf("vec%0d_frame_err", i), cnt_ferr - f0, 32'(vec[i].ferr));
      if (vec[i].valid) check($sformatf("vec%0d_valid_cycle", i), last_valid_cyc, st + ACC_LAT);
      if (vec[i].ferr)  check($sformatf("vec%0d_ferr_cycle", i), last_ferr_cyc, st + STOP_LAT);
    end

    // Short low glitch on an idle line must not start a frame.
    v0 = cnt_valid;
    f0 = cnt_ferr;
    @(negedge clk_100mhz);
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(40);
    check("glitch_pulses", cnt_valid - v0, 0);
    check("glitch_frame_err", cnt_ferr - f0, 0);
    check("glitch_note", 32'(note_out), 0);
    send_frame(8'h81, 1'b1, st);
    idle(4);
    check("after_glitch_note", 32'(note_out), 1);
    check("after_glitch_cycle", last_valid_cyc, st + ACC_LAT);

    // Inactivity timeout.
    send_frame(8'hBC, 1'b1, st);
    acc = st + ACC_LAT;
    v0 = cnt_valid;
    n = 0;
    while (cnt_valid == v0 && n < TO + 100) begin
      @(negedge clk_100mhz);
      n++;
    end
    check("timeout_pulses", cnt_valid - v0, 1);
    check("timeout_cycle", last_valid_cyc, acc + TO);
    check("timeout_note", 32'(note_out), 0);
    idle(50);
    check("timeout_single_pulse", cnt_valid - v0, 1);

    // Reset during DATA with the line held low afterwards.
    send_frame(8'h81, 1'b1, st);
    idle(4);
    check("pre_reset_note", 32'(note_out), 1);
    @(negedge clk_100mhz);
    rx_in = 1'b0;
    idle(60);
    reset = 1'b1;
    idle(3);
    check("midreset_note", 32'(note_out), 0);
    check("midreset_frame_err", 32'(frame_err), 0);
    reset = 1'b0;
    v0 = cnt_valid;
    f0 = cnt_ferr;
    idle(250);
    check("low_after_reset_pulses", cnt_valid - v0, 0);
    check("low_after_reset_frame_err", cnt_ferr - f0, 0);
    rx_in = 1'b1;
    idle(10);
    send_frame(8'h90, 1'b1, st);
    idle(4);
    check("post_reset_note", 32'(note_out), 7'h10);
    check("post_reset_cycle", last_valid_cyc, st + ACC_LAT);

    // Randomized traffic against the byte-level model.
    m_note     = 7'h10;
    m_deadline = st + ACC_LAT + TO;
    e_valid    = 0;
    e_ferr     = 0;
    vb         = cnt_valid;
    fb         = cnt_ferr;
    for (int k = 0; k < 30; k++) begin
      rb  = 8'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      gap = ($urandom_range(0, 9) == 0) ? TO + 100 : int'($urandom_range(2, 300));
      send_frame(rb, ok, st);
      if (ok) begin
        acc = st + ACC_LAT;
        if (m_note != 0 && m_deadline < acc) begin
          m_note = 0;
          e_valid++;
        end
        nn = decode(m_note, rb);
        if (nn != m_note) e_valid++;
        m_note     = nn;
        m_deadline = acc + TO;
      end else begin
        e_ferr++;
        if (m_note != 0 && m_deadline == st + STOP_LAT) m_deadline++;
      end
      idle(gap);
      if (m_note != 0 && m_deadline <= cyc) begin
        m_note = 0;
        e_valid++;
      end
      check($sformatf("rand%0d_note", k), 32'(note_out), 32'(m_note));
      check($sformatf("rand%0d_pulses", k), cnt_valid - vb, e_valid);
      check($sformatf("rand%0d_frame_err", k), cnt_ferr - fb, e_ferr);
    end

    check("valid_ferr_overlap", both_cnt, 0);
    check("change_without_pulse", silent_change, 0);
    check("pulse_without_change", empty_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
